sensor_frame_stat: RTL and testbench
====================================

# sensor_frame_stat

Frame-geometry monitor directly downstream of the sensor pad/phase stage. It consumes the pixel-clock-domain outputs `vacts`, `ihact` and `ipxd[15:0]` and measures the pixels per line and lines per frame for every frame. It flags width and height mismatches against the programmed window, plus VACT arriving inside a line, as sticky errors. Results are read by the CPU status path and used by the compressor control to reject malformed frames.

## Interface
- `WIDTH_BITS`, 14: width of pixel and line counters; matches `hact_length`.
- `clk` input 1: pixel clock, posedge; all logic in this domain.
- `rst_n` input 1: asynchronous active-low reset.
- `en` input 1: 1 means monitor runs; 0 forces IDLE and all outputs hold.
- `vacts` input 1: frame start, single-cycle pulse.
- `ihact` input 1: line active, level.
- `ipxd` input 16: pixel data, valid when `ihact`=1.
- `hact_length` input 14: expected pixels per line minus 1.
- `vact_lines` input 14: expected lines per frame minus 1.
- `err_clr` input 1: single-cycle clear of all sticky errors.
- `line_len` output 14: pixel count of the last completed line.
- `frame_lines` output 14: line count of the last completed frame.
- `frame_done` output 1: single-cycle pulse when a frame closes.
- `frame_ok` output 1: 1 means the last closed frame had no errors.
- `err_width` output 1: sticky; some line length differed from `hact_length`+1.
- `err_height` output 1: sticky; some frame's line count differed from `vact_lines`+1.
- `err_vact_in_line` output 1: sticky; `vacts` arrived while `ihact`=1.
- `frame_sum` output 16: pixel checksum of the last frame. Present only with the macro described in Configuration.

## Operation
- States:
  - IDLE: waiting for the first `vacts` after `en`.
  - GAP: inside a frame, between lines.
  - LINE: `ihact`=1 inside a frame.
- Transitions:
  - IDLE→GAP on `vacts`. Counters clear. No `frame_done`, because no frame was open.
  - GAP→LINE on `ihact`=1.
  - LINE→GAP on `ihact`=0. The line closes.
  - GAP or LINE → GAP on `vacts`. The frame closes and a new frame opens.
  - Any state → IDLE when `en`=0.
- Pixel counter `pix_cnt`:
  - Loads 1 on the GAP→LINE edge.
  - Increments each LINE cycle with `ihact`=1.
  - Saturates at 2^14−1, with no wrap.
- Line close:
  - `line_len` ← `pix_cnt`.
  - `line_cnt` increments, saturating at 2^14−1.
  - If `pix_cnt` ≠ `hact_length`+1, set `err_width` and the internal `frame_bad`.
  - Compare `hact_length`+1 in 15 bits so that 16383+1 does not wrap.
- Frame close, on `vacts` in GAP or LINE:
  - `frame_lines` ← `line_cnt`.
  - `frame_ok` ← !(`frame_bad` | height mismatch | vact-in-line).
  - If `line_cnt` ≠ `vact_lines`+1 (15-bit compare), set `err_height`.
  - `frame_done` pulses.
  - `line_cnt`, `frame_bad` and the checksum clear for the new frame.
- `vacts` while in LINE:
  - Sets `err_vact_in_line`.
  - The partial line is discarded: not counted, no width check, `line_len` unchanged.
  - The state goes to GAP. A `ihact` still high is ignored until it has been seen low.
- `vacts` and `ihact` rising in the same cycle (from GAP): the frame closes, and the new frame starts directly in LINE with `pix_cnt`=1.
- `err_clr` and an error set in the same cycle: set wins.
- `en` falling mid-frame: the open frame is abandoned with no `frame_done`, and the last results hold. `en` rising needs a fresh `vacts`.
- `hact_length` and `vact_lines` are sampled at each compare. The CPU changes them only between frames.

## Timing
- All outputs are registered.
- Reset values:
  - Counters, `line_len`, `frame_lines` and `frame_sum`: 0.
  - `frame_done`: 0.
  - `frame_ok`: 0.
  - All `err_*`: 0.
  - State: IDLE.
- Line close: `ihact` low sampled at edge N; `line_len` and `err_width` are valid after edge N.
- Frame close: `vacts` sampled at edge N; `frame_done`, `frame_lines`, `frame_ok`, `err_height` and `frame_sum` are valid after edge N for one cycle. Results hold until the next frame close.
- No throughput limit: a 1-cycle GAP between lines is legal, and so is a 1-pixel line.

## Configuration
- `SENSOR_FRAME_STAT_CHECKSUM_EN` defined:
  - A 16-bit accumulator adds `ipxd` on every counted LINE cycle, modulo 2^16.
  - It is latched to `frame_sum` at frame close and cleared for the new frame.
  - Pixels of discarded partial lines are excluded.
- Not defined: the `frame_sum` port is absent, with no accumulator logic.

## Test plan
- Window check, 4 frames:
  - Stimulus: `hact_length`=7, `vact_lines`=3, each frame 4 lines of 8 pixels with 3-cycle gaps.
  - Required: `line_len`=8, `frame_lines`=4, `frame_done` on the 2nd/3rd/4th `vacts`, `frame_ok`=1, no errors.
- Short line:
  - Stimulus: the 3rd line of a frame is 7 pixels.
  - Required: `err_width`=1 after that line, `frame_ok`=0 at close; the next clean frame gives `frame_ok`=1 and `err_width` still 1 until `err_clr`.
- Height mismatch:
  - Stimulus: a frame with 5 lines.
  - Required: `frame_lines`=5, `err_height`=1.
- `vacts` during line:
  - Stimulus: pixel 4 of line 2.
  - Required: `err_vact_in_line`=1, `frame_lines`=1, `line_len` stays 8.
- Simultaneous events:
  - Stimulus: `vacts` and `ihact` rise together; separately, `err_clr` coincides with a width error.
  - Required: the new line counts from 1; the error remains set.
- Checksum (macro defined):
  - Stimulus: `ipxd`=16'hFFFF for 2 pixels.
  - Required: `frame_sum`=16'hFFFE.
- Reset: asserting `rst_n` low mid-line returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/sensor_frame_stat.sv
// Frame-geometry monitor: measures pixels/line and lines/frame, flags sticky geometry errors.
// Optional per-frame pixel checksum when SENSOR_FRAME_STAT_CHECKSUM_EN is defined.
module sensor_frame_stat #(
    parameter int WIDTH_BITS = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  vacts,
    input  logic                  ihact,
    input  logic [15:0]           ipxd,
    input  logic [WIDTH_BITS-1:0] hact_length,
    input  logic [WIDTH_BITS-1:0] vact_lines,
    input  logic                  err_clr,
    output logic [WIDTH_BITS-1:0] line_len,
    output logic [WIDTH_BITS-1:0] frame_lines,
    output logic                  frame_done,
    output logic                  frame_ok,
    output logic                  err_width,
    output logic                  err_height,
    output logic                  err_vact_in_line
`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
    ,
    output logic [15:0]           frame_sum
`endif
);

    localparam int W = WIDTH_BITS;
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    typedef enum logic [1:0] {IDLE, GAP, LINE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [W-1:0]   line_cnt_q, line_cnt_d;
    logic           frame_bad_q, frame_bad_d;
    logic           wait_low_q, wait_low_d;
    logic [W-1:0]   line_len_q, line_len_d;
    logic [W-1:0]   frame_lines_q, frame_lines_d;
    logic           frame_done_q, frame_done_d;
    logic           frame_ok_q, frame_ok_d;
    logic           err_width_q, err_width_d;
    logic           err_height_q, err_height_d;
    logic           err_vil_q, err_vil_d;
`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
    logic [15:0]    line_acc_q, line_acc_d;
    logic [15:0]    frame_acc_q, frame_acc_d;
    logic [15:0]    frame_sum_q, frame_sum_d;
`else
    logic           unused_pxd;
    assign unused_pxd = ^ipxd;
`endif

    // Expected counts are widened so hact_length/vact_lines of all-ones do not wrap.
    logic [W:0] exp_pix, exp_lines;
    assign exp_pix   = {1'b0, hact_length} + 1'b1;
    assign exp_lines = {1'b0, vact_lines} + 1'b1;

    logic           line_close, frame_close, line_start, set_w, set_h, set_v;
    logic [W-1:0]   lines_now;
    logic           bad_now;

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        frame_bad_d   = frame_bad_q;
        wait_low_d    = wait_low_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        frame_done_d  = 1'b0;
        frame_ok_d    = frame_ok_q;
        err_width_d   = err_width_q;
        err_height_d  = err_height_q;
        err_vil_d     = err_vil_q;
`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
        line_acc_d    = line_acc_q;
        frame_acc_d   = frame_acc_q;
        frame_sum_d   = frame_sum_q;
`endif
        line_close  = 1'b0;
        frame_close = 1'b0;
        line_start  = 1'b0;
        set_w       = 1'b0;
        set_h       = 1'b0;
        set_v       = 1'b0;
        lines_now   = line_cnt_q;
        bad_now     = frame_bad_q;

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vacts) begin
                        state_d     = GAP;
                        pix_cnt_d   = '0;
                        line_cnt_d  = '0;
                        frame_bad_d = 1'b0;
                        wait_low_d  = 1'b0;
`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
                        frame_acc_d = '0;
`endif
                        line_start  = ihact;
                    end
                end
                GAP: begin
                    if (!ihact) wait_low_d = 1'b0;
                    frame_close = vacts;
                    line_start  = ihact && !wait_low_q;
                end
                LINE: begin
                    if (ihact && vacts) begin
                        // Partial line is dropped; hold off until ihact is seen low.
                        set_v       = 1'b1;
                        frame_close = 1'b1;
                        wait_low_d  = 1'b1;
                        state_d     = GAP;
                    end else if (ihact) begin
                        pix_cnt_d = (pix_cnt_q == CNT_MAX) ? CNT_MAX : pix_cnt_q + 1'b1;
`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
                        line_acc_d = line_acc_q + ipxd;
`endif
                    end else begin
                        line_close  = 1'b1;
                        frame_close = vacts;
                        state_d     = GAP;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (line_close) begin
                line_len_d  = pix_cnt_q;
                lines_now   = (line_cnt_q == CNT_MAX) ? CNT_MAX : line_cnt_q + 1'b1;
                set_w       = ({1'b0, pix_cnt_q} != exp_pix);
                bad_now     = frame_bad_q | set_w;
                line_cnt_d  = lines_now;
                frame_bad_d = bad_now;
`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
                frame_acc_d = frame_acc_q + line_acc_q;
`endif
            end

            if (frame_close) begin
                set_h         = ({1'b0, lines_now} != exp_lines);
                frame_lines_d = lines_now;
                frame_ok_d    = !(bad_now | set_h | set_v);
                frame_done_d  = 1'b1;
                line_cnt_d    = '0;
                frame_bad_d   = 1'b0;
`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
                frame_sum_d   = frame_acc_d;
                frame_acc_d   = '0;
`endif
            end

            if (line_start) begin
                state_d   = LINE;
                pix_cnt_d = {{(W-1){1'b0}}, 1'b1};
`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
                line_acc_d = ipxd;
`endif
            end

            // A set in the same cycle as err_clr wins.
            err_width_d  = set_w | (err_width_q  & !err_clr);
            err_height_d = set_h | (err_height_q & !err_clr);
            err_vil_d    = set_v | (err_vil_q    & !err_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            frame_bad_q   <= 1'b0;
            wait_low_q    <= 1'b0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            err_width_q   <= 1'b0;
            err_height_q  <= 1'b0;
            err_vil_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            frame_bad_q   <= frame_bad_d;
            wait_low_q    <= wait_low_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            frame_done_q  <= frame_done_d;
            frame_ok_q    <= frame_ok_d;
            err_width_q   <= err_width_d;
            err_height_q  <= err_height_d;
            err_vil_q     <= err_vil_d;
        end
    end

`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_acc_q  <= '0;
            frame_acc_q <= '0;
            frame_sum_q <= '0;
        end else begin
            line_acc_q  <= line_acc_d;
            frame_acc_q <= frame_acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end
    assign frame_sum = frame_sum_q;
`endif

    assign line_len         = line_len_q;
    assign frame_lines      = frame_lines_q;
    assign frame_done       = frame_done_q;
    assign frame_ok         = frame_ok_q;
    assign err_width        = err_width_q;
    assign err_height       = err_height_q;
    assign err_vact_in_line = err_vil_q;

endmodule

// File: tb/tb_sensor_frame_stat.sv
// Directed self-checking bench for sensor_frame_stat (checksum cases when the macro is defined).
module tb_sensor_frame_stat;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0, vacts = 1'b0, ihact = 1'b0, err_clr = 1'b0;
    logic [15:0] ipxd = '0;
    logic [13:0] hact_length = 14'd7, vact_lines = 14'd3;
    logic [13:0] line_len, frame_lines;
    logic        frame_done, frame_ok, err_width, err_height, err_vact_in_line;
`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
    logic [15:0] frame_sum;
`endif
    int tests = 0, fails = 0;

    sensor_frame_stat #(.WIDTH_BITS(14)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .vacts(vacts), .ihact(ihact), .ipxd(ipxd),
        .hact_length(hact_length), .vact_lines(vact_lines), .err_clr(err_clr),
        .line_len(line_len), .frame_lines(frame_lines), .frame_done(frame_done),
        .frame_ok(frame_ok), .err_width(err_width), .err_height(err_height),
        .err_vact_in_line(err_vact_in_line)
`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
        , .frame_sum(frame_sum)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic vpulse();
        vacts = 1'b1; cyc(); vacts = 1'b0;
    endtask

    task automatic send_line(input int n, input int gap, input logic [15:0] d);
        ihact = 1'b1; ipxd = d;
        repeat (n) cyc();
        ihact = 1'b0;
        repeat (gap) cyc();
    endtask

    task automatic clr_errs();
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        cyc(); cyc();
        tests++; if (line_len !== 14'd0) begin fails++; $display("FAIL reset_line_len got %0d exp 0", line_len); end
        tests++; if (frame_lines !== 14'd0) begin fails++; $display("FAIL reset_frame_lines got %0d exp 0", frame_lines); end
        tests++; if ({frame_done, frame_ok, err_width, err_height, err_vact_in_line} !== 5'b0)
            begin fails++; $display("FAIL reset_flags got %b exp 00000", {frame_done, frame_ok, err_width, err_height, err_vact_in_line}); end
        rst_n = 1'b1; en = 1'b1;
        cyc();
    endtask

    task automatic test_window();
        for (int f = 0; f < 4; f++) begin
            vpulse();
            tests++; if (frame_done !== (f > 0)) begin fails++; $display("FAIL win_done f%0d got %b exp %b", f, frame_done, (f > 0)); end
            for (int l = 0; l < 4; l++) send_line(8, 3, 16'h0010);
            tests++; if (line_len !== 14'd8) begin fails++; $display("FAIL win_line_len f%0d got %0d exp 8", f, line_len); end
        end
        vpulse();
        tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL win_last_done got %b exp 1", frame_done); end
        tests++; if (frame_lines !== 14'd4) begin fails++; $display("FAIL win_frame_lines got %0d exp 4", frame_lines); end
        tests++; if (frame_ok !== 1'b1) begin fails++; $display("FAIL win_ok got %b exp 1", frame_ok); end
        tests++; if ({err_width, err_height, err_vact_in_line} !== 3'b0) begin fails++; $display("FAIL win_errs got %b exp 000", {err_width, err_height, err_vact_in_line}); end
        cyc();
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL win_done_pulse got %b exp 0", frame_done); end
    endtask

    task automatic test_short_line();
        send_line(8, 3, 16'h1); send_line(8, 3, 16'h1); send_line(7, 3, 16'h1);
        tests++; if (err_width !== 1'b1) begin fails++; $display("FAIL short_err_width got %b exp 1", err_width); end
        tests++; if (line_len !== 14'd7) begin fails++; $display("FAIL short_line_len got %0d exp 7", line_len); end
        send_line(8, 3, 16'h1);
        vpulse();
        tests++; if (frame_ok !== 1'b0) begin fails++; $display("FAIL short_ok got %b exp 0", frame_ok); end
        tests++; if (frame_lines !== 14'd4) begin fails++; $display("FAIL short_lines got %0d exp 4", frame_lines); end
        for (int l = 0; l < 4; l++) send_line(8, 3, 16'h1);
        vpulse();
        tests++; if (frame_ok !== 1'b1) begin fails++; $display("FAIL short_next_ok got %b exp 1", frame_ok); end
        tests++; if (err_width !== 1'b1) begin fails++; $display("FAIL short_sticky got %b exp 1", err_width); end
        clr_errs();
        tests++; if (err_width !== 1'b0) begin fails++; $display("FAIL short_clr got %b exp 0", err_width); end
    endtask

    task automatic test_height();
        for (int l = 0; l < 5; l++) send_line(8, 2, 16'h2);
        vpulse();
        tests++; if (frame_lines !== 14'd5) begin fails++; $display("FAIL height_lines got %0d exp 5", frame_lines); end
        tests++; if (err_height !== 1'b1) begin fails++; $display("FAIL height_err got %b exp 1", err_height); end
        tests++; if (frame_ok !== 1'b0) begin fails++; $display("FAIL height_ok got %b exp 0", frame_ok); end
        clr_errs();
        tests++; if (err_height !== 1'b0) begin fails++; $display("FAIL height_clr got %b exp 0", err_height); end
    endtask

    task automatic test_vact_in_line();
        send_line(8, 3, 16'h3);
        ihact = 1'b1;
        repeat (3) cyc();
        vacts = 1'b1; cyc(); vacts = 1'b0;
        tests++; if (err_vact_in_line !== 1'b1) begin fails++; $display("FAIL vil_err got %b exp 1", err_vact_in_line); end
        tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL vil_done got %b exp 1", frame_done); end
        tests++; if (frame_lines !== 14'd1) begin fails++; $display("FAIL vil_lines got %0d exp 1", frame_lines); end
        tests++; if (frame_ok !== 1'b0) begin fails++; $display("FAIL vil_ok got %b exp 0", frame_ok); end
        repeat (2) cyc();
        ihact = 1'b0; cyc(); cyc();
        tests++; if (line_len !== 14'd8) begin fails++; $display("FAIL vil_line_len got %0d exp 8", line_len); end
        tests++; if (err_width !== 1'b0) begin fails++; $display("FAIL vil_no_width got %b exp 0", err_width); end
        clr_errs();
        tests++; if (err_vact_in_line !== 1'b0) begin fails++; $display("FAIL vil_clr got %b exp 0", err_vact_in_line); end
    endtask

    task automatic test_simultaneous();
        vacts = 1'b1; ihact = 1'b1; cyc(); vacts = 1'b0;
        tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL sim_done got %b exp 1", frame_done); end
        tests++; if (err_vact_in_line !== 1'b0) begin fails++; $display("FAIL sim_no_vil got %b exp 0", err_vact_in_line); end
        repeat (7) cyc();
        ihact = 1'b0; cyc();
        tests++; if (line_len !== 14'd8) begin fails++; $display("FAIL sim_line_len got %0d exp 8", line_len); end
        tests++; if (err_width !== 1'b0) begin fails++; $display("FAIL sim_width got %b exp 0", err_width); end
        ihact = 1'b1; repeat (5) cyc();
        ihact = 1'b0; err_clr = 1'b1; cyc(); err_clr = 1'b0;
        tests++; if (err_width !== 1'b1) begin fails++; $display("FAIL clr_vs_set got %b exp 1", err_width); end
        tests++; if (line_len !== 14'd5) begin fails++; $display("FAIL clr_vs_set_len got %0d exp 5", line_len); end
        send_line(1, 1, 16'h4);
        tests++; if (line_len !== 14'd1) begin fails++; $display("FAIL one_pix got %0d exp 1", line_len); end
        send_line(8, 1, 16'h4);
        tests++; if (line_len !== 14'd8) begin fails++; $display("FAIL one_gap got %0d exp 8", line_len); end
    endtask

    task automatic test_enable();
        ihact = 1'b1; repeat (3) cyc();
        en = 1'b0; cyc();
        ihact = 1'b0; cyc();
        tests++; if (line_len !== 14'd8) begin fails++; $display("FAIL en_hold_len got %0d exp 8", line_len); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL en_off_done got %b exp 0", frame_done); end
        en = 1'b1; cyc();
        vpulse();
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL en_first_vacts got %b exp 0", frame_done); end
        send_line(8, 1, 16'h5);
        vpulse();
        tests++; if (frame_lines !== 14'd1) begin fails++; $display("FAIL en_lines got %0d exp 1", frame_lines); end
        tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL en_done got %b exp 1", frame_done); end
    endtask

`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
    task automatic test_checksum();
        send_line(2, 1, 16'hFFFF);
        vpulse();
        tests++; if (frame_sum !== 16'hFFFE) begin fails++; $display("FAIL sum_wrap got %h exp fffe", frame_sum); end
        send_line(1, 1, 16'h0001);
        ihact = 1'b1; ipxd = 16'h0100; repeat (2) cyc();
        vacts = 1'b1; cyc(); vacts = 1'b0;
        tests++; if (frame_sum !== 16'h0001) begin fails++; $display("FAIL sum_partial got %h exp 0001", frame_sum); end
        ihact = 1'b0; cyc();
        clr_errs();
    endtask
`endif

    task automatic test_async_reset();
        vpulse();
        ihact = 1'b1; repeat (3) cyc();
        @(negedge clk); rst_n = 1'b0; #1;
        tests++; if (line_len !== 14'd0) begin fails++; $display("FAIL areset_len got %0d exp 0", line_len); end
        tests++; if (frame_lines !== 14'd0) begin fails++; $display("FAIL areset_lines got %0d exp 0", frame_lines); end
        tests++; if ({frame_done, frame_ok, err_width, err_height, err_vact_in_line} !== 5'b0)
            begin fails++; $display("FAIL areset_flags got %b exp 00000", {frame_done, frame_ok, err_width, err_height, err_vact_in_line}); end
        ihact = 1'b0; cyc();
        rst_n = 1'b1; cyc();
    endtask

    initial begin
        test_reset();
        test_window();
        test_short_line();
        test_height();
        test_vact_in_line();
        test_simultaneous();
        test_enable();
`ifdef SENSOR_FRAME_STAT_CHECKSUM_EN
        test_checksum();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
